// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder
// Receive side of the VGA timing interface. Recovers pixel coordinates and
// the active-video flag from HSync/VSync, checks line/frame timing and
// reports lock status and timing errors. All outputs are registered and
// trail the sampled sync inputs by a fixed two clocks.
module vga_sync_decoder #(
    parameter int WIDTH        = 640,
    parameter int HEIGHT       = 480,
    parameter int H_SYNC_WIDTH = 96,
    parameter int H_BACK_PORCH = 48,
    parameter int H_TOTAL      = 800,
    parameter int V_SYNC_WIDTH = 2,
    parameter int V_BACK_PORCH = 31,
    parameter int V_TOTAL      = 524,
    parameter int LOCK_FRAMES  = 2
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_HSync,
    input  logic        i_VSync,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_Valid,
    output logic        o_Locked,
    output logic        o_FrameStart,
    output logic        o_Err
);

    localparam logic [11:0] HA_C           = 12'(H_SYNC_WIDTH + H_BACK_PORCH);
    localparam logic [11:0] HA_END_C       = 12'(H_SYNC_WIDTH + H_BACK_PORCH + WIDTH - 1);
    localparam logic [11:0] VA_C           = 12'(V_SYNC_WIDTH + V_BACK_PORCH);
    localparam logic [11:0] VA_END_C       = 12'(V_SYNC_WIDTH + V_BACK_PORCH + HEIGHT - 1);
    localparam logic [12:0] H_TOTAL_C      = 13'(H_TOTAL);
    localparam logic [12:0] V_TOTAL_C      = 13'(V_TOTAL);
    localparam logic [11:0] H_SYNC_C       = 12'(H_SYNC_WIDTH);
    localparam logic [11:0] V_SYNC_C       = 12'(V_SYNC_WIDTH);
    localparam logic [11:0] TIMEOUT_LAST_C = 12'(2 * H_TOTAL - 1);
    localparam logic [3:0]  LOCK_C         = 4'(LOCK_FRAMES);
    localparam logic [11:0] CNT_MAX_C      = 12'hFFF;

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

    logic        hs_r, vs_r, hs_d_r, vs_rise_r, fs_r, err_r;
    logic [11:0] hc_r, vc_r, hsw_r, vsw_r;
    logic [3:0]  good_r, good_next_s;
    state_t      state_r, state_next_s;

    logic        hrise_s, fs_s, line_bad_s, frame_bad_s, timeout_s, err_s;
    logic        locked_s, active_s, valid_s, frame_start_s;
    logic [11:0] x_s, y_s;

    // Frame start is a line start where VSync is high but was low at the previous line start
    assign hrise_s = hs_r & ~hs_d_r;
    assign fs_s    = hrise_s & vs_r & ~vs_rise_r;

    // Register the sync inputs once and keep a delayed HSync for edge detection
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hs_r   <= 1'b0;
            vs_r   <= 1'b0;
            hs_d_r <= 1'b0;
        end else begin
            hs_r   <= i_HSync;
            vs_r   <= i_VSync;
            hs_d_r <= hs_r;
        end
    end

    // Position counters and sync-width measurements, all saturating
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            hc_r      <= 12'd0;
            vc_r      <= 12'd0;
            hsw_r     <= 12'd0;
            vsw_r     <= 12'd0;
            vs_rise_r <= 1'b0;
            fs_r      <= 1'b0;
        end else begin
            fs_r <= fs_s;
            if (hrise_s) begin
                hc_r      <= 12'd0;
                hsw_r     <= 12'd1;
                vs_rise_r <= vs_r;
            end else begin
                hc_r  <= (hc_r != CNT_MAX_C) ? hc_r + 12'd1 : hc_r;
                hsw_r <= (hs_r && hsw_r != CNT_MAX_C) ? hsw_r + 12'd1 : hsw_r;
            end
            if (fs_s) begin
                vc_r  <= 12'd0;
                vsw_r <= 12'd1;
            end else if (hrise_s) begin
                vc_r  <= (vc_r != CNT_MAX_C) ? vc_r + 12'd1 : vc_r;
                vsw_r <= (vs_r && vsw_r != CNT_MAX_C) ? vsw_r + 12'd1 : vsw_r;
            end else begin
                vc_r  <= vc_r;
                vsw_r <= vsw_r;
            end
        end
    end

    // Timing checks; the counters still hold the previous line/frame on the check cycle
    always_comb begin
        line_bad_s  = (({1'b0, hc_r} + 13'd1) != H_TOTAL_C) || (hsw_r != H_SYNC_C);
        frame_bad_s = (({1'b0, vc_r} + 13'd1) != V_TOTAL_C) || (vsw_r != V_SYNC_C);
        timeout_s   = !hrise_s && (hc_r == TIMEOUT_LAST_C);
        if (state_r == ST_SEARCH) begin
            err_s = 1'b0;
        end else begin
            err_s = (hrise_s && line_bad_s) || (fs_s && frame_bad_s) || timeout_s;
        end
    end

    // Lock state register, good-frame count and error pulse
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_r <= ST_SEARCH;
            good_r  <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            good_r  <= good_next_s;
            err_r   <= err_s;
        end
    end

    // Lock state transitions: errors always fall back to SEARCH
    always_comb begin
        state_next_s = state_r;
        good_next_s  = good_r;
        case (state_r)
            ST_SEARCH: begin
                if (fs_s) begin
                    state_next_s = ST_ACQUIRE;
                    good_next_s  = 4'd0;
                end else begin
                    state_next_s = ST_SEARCH;
                end
            end
            ST_ACQUIRE: begin
                if (err_s) begin
                    state_next_s = ST_SEARCH;
                    good_next_s  = 4'd0;
                end else if (fs_s) begin
                    good_next_s = good_r + 4'd1;
                    if ((good_r + 4'd1) == LOCK_C) begin
                        state_next_s = ST_LOCKED;
                    end else begin
                        state_next_s = ST_ACQUIRE;
                    end
                end else begin
                    state_next_s = ST_ACQUIRE;
                end
            end
            ST_LOCKED: begin
                if (err_s) begin
                    state_next_s = ST_SEARCH;
                    good_next_s  = 4'd0;
                end else begin
                    state_next_s = ST_LOCKED;
                end
            end
            default: begin
                state_next_s = ST_SEARCH;
                good_next_s  = 4'd0;
            end
        endcase
    end

    // Decode the pixel currently described by the counters
    always_comb begin
        locked_s = (state_r == ST_LOCKED);
        active_s = (hc_r >= HA_C) && (hc_r <= HA_END_C) &&
                   (vc_r >= VA_C) && (vc_r <= VA_END_C);
        if (locked_s && active_s) begin
            valid_s = 1'b1;
            x_s     = hc_r - HA_C;
            y_s     = vc_r - VA_C;
        end else begin
            valid_s = 1'b0;
            x_s     = 12'd0;
            y_s     = 12'd0;
        end
        frame_start_s = locked_s && fs_r;
    end

    // Output registers, forming the second pipeline stage
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            o_x          <= 12'd0;
            o_y          <= 12'd0;
            o_Valid      <= 1'b0;
            o_Locked     <= 1'b0;
            o_FrameStart <= 1'b0;
            o_Err        <= 1'b0;
        end else begin
            o_x          <= x_s;
            o_y          <= y_s;
            o_Valid      <= valid_s;
            o_Locked     <= locked_s;
            o_FrameStart <= frame_start_s;
            o_Err        <= err_r;
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Testbench for vga_sync_decoder using a reduced timing (16 clocks x 10 lines)
// so that many frames fit in a short run. Stimulus pushes the expected
// output event for each pixel into a queue; a monitor pops and compares
// whenever the DUT presents valid/err/frame-start or a lock change.
module tb_vga_sync_decoder;
    localparam int HT  = 16;
    localparam int HSW = 3;
    localparam int HBP = 2;
    localparam int W   = 8;
    localparam int VSW = 2;
    localparam int VBP = 1;
    localparam int H   = 4;
    localparam int VT  = 10;
    localparam int LF  = 2;
    localparam int HA  = HSW + HBP;
    localparam int VA  = VSW + VBP;

    logic        clk = 1'b0;
    logic        rst, hs, vs;
    logic [11:0] ox, oy;
    logic        ovalid, olocked, ofs, oerr;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .WIDTH(W), .HEIGHT(H), .H_SYNC_WIDTH(HSW), .H_BACK_PORCH(HBP),
        .H_TOTAL(HT), .V_SYNC_WIDTH(VSW), .V_BACK_PORCH(VBP), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .i_Clk(clk), .i_Reset(rst), .i_HSync(hs), .i_VSync(vs),
        .o_x(ox), .o_y(oy), .o_Valid(ovalid), .o_Locked(olocked),
        .o_FrameStart(ofs), .o_Err(oerr)
    );

    typedef struct {
        int          due;
        logic [11:0] x;
        logic [11:0] y;
        logic        valid;
        logic        fs;
        logic        err;
        logic        lock;
    } ev_t;

    ev_t  sb[$];
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    bit   mon_on = 1'b0;
    logic last_locked = 1'b0;
    bit   exp_lock = 1'b0;
    bit   last_exp_lock = 1'b0;

    // Monitor: one sample 1 time unit after every rising edge
    initial begin
        ev_t cur;
        forever begin
            @(posedge clk);
            #1;
            cyc = cyc + 1;
            if (mon_on) begin
                while (sb.size() > 0 && sb[0].due < cyc) begin
                    cur = sb.pop_front();
                    total++;
                    bad++;
                    $display("FAIL missed_event cyc=%0d due=%0d: got no output event, required valid=%0b x=%0d y=%0d fs=%0b err=%0b locked=%0b",
                             cyc, cur.due, cur.valid, cur.x, cur.y, cur.fs, cur.err, cur.lock);
                end
                if (ovalid || oerr || ofs || (olocked !== last_locked)) begin
                    total++;
                    if (sb.size() == 0 || sb[0].due != cyc) begin
                        bad++;
                        $display("FAIL unexpected_event cyc=%0d: got valid=%0b x=%0d y=%0d fs=%0b err=%0b locked=%0b, required no event",
                                 cyc, ovalid, ox, oy, ofs, oerr, olocked);
                    end else begin
                        cur = sb.pop_front();
                        if ({ovalid, ox, oy, ofs, oerr, olocked} !==
                            {cur.valid, cur.x, cur.y, cur.fs, cur.err, cur.lock}) begin
                            bad++;
                            $display("FAIL event_fields cyc=%0d: got valid=%0b x=%0d y=%0d fs=%0b err=%0b locked=%0b, required valid=%0b x=%0d y=%0d fs=%0b err=%0b locked=%0b",
                                     cyc, ovalid, ox, oy, ofs, oerr, olocked,
                                     cur.valid, cur.x, cur.y, cur.fs, cur.err, cur.lock);
                        end
                    end
                end
                last_locked = olocked;
            end
        end
    end

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Drive one pixel and queue the output event it should produce 2 clocks later
    task automatic drive_pix(input bit h_s, input bit v_s, input int v, input int h,
                             input bit err_here, input bit lock_here);
        ev_t e;
        bit  act;
        @(negedge clk);
        hs = h_s;
        vs = v_s;
        if (lock_here) exp_lock = 1'b1;
        if (err_here)  exp_lock = 1'b0;
        act     = (h >= HA) && (h < HA + W) && (v >= VA) && (v < VA + H);
        e.due   = cyc + 3;
        e.valid = exp_lock && act;
        e.x     = e.valid ? 12'(h - HA) : 12'd0;
        e.y     = e.valid ? 12'(v - VA) : 12'd0;
        e.fs    = exp_lock && (h == 0) && (v == 0);
        e.err   = err_here;
        e.lock  = exp_lock;
        if (e.valid || e.fs || e.err || (exp_lock != last_exp_lock)) sb.push_back(e);
        last_exp_lock = exp_lock;
    endtask

    task automatic send_line(input int v, input int len, input int hsw,
                             input bit err0, input bit lock0);
        for (int h = 0; h < len; h++)
            drive_pix(h < hsw, v < VSW, v, h, err0 && (h == 0), lock0 && (h == 0));
    endtask

    // long_line/short_line (-1 = none) distort one line; the error shows at the next line start
    task automatic send_frame(input int nlines, input bit lock_fs, input bit err_fs,
                              input int long_line, input int short_line);
        for (int v = 0; v < nlines; v++)
            send_line(v, (v == long_line) ? HT + 1 : HT,
                      (v == short_line) ? HSW - 1 : HSW,
                      (v == 0 && err_fs) ||
                      (long_line >= 0 && v == long_line + 1) ||
                      (short_line >= 0 && v == short_line + 1),
                      (v == 0) && lock_fs);
    endtask

    // Last HSync pulse of line v, then HSync held low; error 2*HT clocks after the rise
    task automatic send_timeout(input int v, input int hold);
        for (int h = 0; h < hold; h++)
            drive_pix(h < HSW, 1'b0, v, h, h == 2 * HT, 1'b0);
    endtask

    task automatic do_reset();
        ev_t e;
        @(negedge clk);
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        while (sb.size() > 0 && sb[sb.size() - 1].due > cyc) void'(sb.pop_back());
        if (exp_lock) begin
            e.due = cyc + 1; e.x = 12'd0; e.y = 12'd0;
            e.valid = 1'b0; e.fs = 1'b0; e.err = 1'b0; e.lock = 1'b0;
            sb.push_back(e);
        end
        exp_lock      = 1'b0;
        last_exp_lock = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        hs  = 1'b0;
        vs  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_x", ox, 12'd0);
        check("reset_y", oy, 12'd0);
        check("reset_valid", {11'd0, ovalid}, 12'd0);
        check("reset_locked", {11'd0, olocked}, 12'd0);
        check("reset_framestart", {11'd0, ofs}, 12'd0);
        check("reset_err", {11'd0, oerr}, 12'd0);
        mon_on = 1'b1;

        // Clean stream: lock at the third frame start, then a full locked frame
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b1, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        // One line one clock long, relock three frame starts later
        send_frame(VT, 1'b0, 1'b0, 5, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        // Relock, then one HSync pulse one clock short
        send_frame(VT, 1'b1, 1'b0, -1, 2);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        // Relock, then HSync stops mid-frame
        send_frame(8, 1'b1, 1'b0, -1, -1);
        send_timeout(8, 60);
        // Reacquire from a fresh frame start, then reset mid-line while locked
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(4, 1'b1, 1'b0, -1, -1);
        send_line(4, 8, HSW, 1'b0, 1'b0);
        do_reset();
        // Same lock timing after reset, then a frame with one extra line
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b0, -1, -1);
        send_frame(VT + 1, 1'b1, 1'b0, -1, -1);
        send_frame(VT, 1'b0, 1'b1, -1, -1);
        repeat (20) begin
            @(negedge clk);
            hs = 1'b0;
            vs = 1'b0;
        end
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL leftover_event due=%0d: got no output event, required valid=%0b x=%0d y=%0d fs=%0b err=%0b locked=%0b",
                     e.due, e.valid, e.x, e.y, e.fs, e.err, e.lock);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
